// File: rtl/kp_pkg.sv
// Keypad scanner shared types and helpers.
// Holds FSM states, the default 4x4 keymap and one-hot utilities.
package kp_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } kp_state_t;

  // Row 0 is the most significant group; entry 0 is row 0 / col 0.
  localparam logic [63:0] DEFAULT_KEYMAP_4X4 = {
    4'd1,  4'd2, 4'd3,  4'd10,
    4'd4,  4'd5, 4'd6,  4'd11,
    4'd7,  4'd8, 4'd9,  4'd12,
    4'd14, 4'd0, 4'd15, 4'd13
  };

  function automatic int onehot_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++)
      if (v[i]) idx = i;
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin-side bundle of the keypad scanner.
// master = keypad/environment side, slave = scanner side.
interface keypad_scanner_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = 4
);
  logic [COLS-1:0]   cols_raw;
  logic [ROWS-1:0]   rows;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;

  modport master (
    output cols_raw,
    input  rows, key_code, key_valid, key_held
  );

  modport slave (
    input  cols_raw,
    output rows, key_code, key_valid, key_held
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Reset clears both stages.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;

  // shift the raw value through two stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row strobes, debounce, keymap decode.
// One key_valid strobe per debounced press, no rollover.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int CODE_W          = 4,
  parameter logic [ROWS*COLS*CODE_W-1:0] KEYMAP = DEFAULT_KEYMAP_4X4,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic             clk,
  input logic             reset_n,
  keypad_scanner_if.slave kp
);
  localparam int MX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ?
                      SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam int NK = ROWS * COLS;
  localparam logic [CW-1:0] SET_C = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  kp_state_t         state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ROWS-1:0]   rows, rows_n, rows_rot;
  logic [COLS-1:0]   cols_s, cand, cand_n;
  logic              accept, valid_q;
  logic [CODE_W-1:0] code_q, code_n;
  int                key_idx;

  sync_2ff #(.W(COLS)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (kp.cols_raw),
    .q       (cols_s)
  );

  assign rows_rot = {rows[ROWS-2:0], rows[ROWS-1]};
  assign key_idx  = onehot_idx(32'(rows)) * COLS
                  + onehot_idx(32'(cand));

  // keymap lookup for the candidate key (row 0 in the MSBs)
  always_comb begin
    code_n = KEYMAP[(NK - 1 - key_idx) * CODE_W +: CODE_W];
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SCAN;
      cnt     <= '0;
      rows    <= ROWS'(1);
      cand    <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rows    <= rows_n;
      cand    <= cand_n;
      valid_q <= accept;
      if (accept) code_q <= code_n;
    end
  end

  // next-state: scan rows, debounce a single column, wait for release
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rows_n  = rows;
    cand_n  = cand;
    accept  = 1'b0;
    unique case (1'b1)
      (state == SCAN): begin
        if (cnt != SET_C) begin
          cnt_n = cnt + ONE;
        end else begin
          cnt_n = '0;
          if (is_onehot(32'(cols_s))) begin
            cand_n  = cols_s;
            state_n = DEBOUNCE;
          end else begin
            rows_n = rows_rot;
          end
        end
      end
      (state == DEBOUNCE): begin
        if (cols_s != cand) begin
          state_n = SCAN;
          cnt_n   = '0;
        end else if (cnt == DEB_C) begin
          state_n = PRESSED;
          cnt_n   = '0;
          accept  = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      (state == PRESSED): begin
        if ((cols_s & cand) != '0) begin
          cnt_n = '0;
        end else if (cnt == DEB_C) begin
          state_n = SCAN;
          cnt_n   = '0;
          rows_n  = rows_rot;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = SCAN;
        cnt_n   = '0;
      end
    endcase
  end

  // outputs
  always_comb begin
    kp.rows      = rows;
    kp.key_code  = code_q;
    kp.key_valid = valid_q;
    kp.key_held  = (state == PRESSED);
  end
endmodule
